// File: rtl/if_id_pipe_reg_if.sv
// rtl/if_id_pipe_reg_if.sv - IF/ID pipeline register bus (fetch/hazard side in, decode side out)
// Optional: IF_ID_STATS_EN adds stall_cnt_o / bubble_cnt_o.
interface if_id_pipe_reg_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] PC_i;
  logic [XLEN-1:0] instr_i;
  logic            instr_valid_i;
  logic            stall_i;
  logic            mem_stall_i;
  logic            flush_i;
  logic [XLEN-1:0] PC_o;
  logic [XLEN-1:0] instr_o;
  logic            valid_o;
  logic [4:0]      RS1addr_o;
  logic [4:0]      RS2addr_o;
  logic            flush_pending_o;
`ifdef IF_ID_STATS_EN
  logic [31:0]     stall_cnt_o;
  logic [31:0]     bubble_cnt_o;
`endif

  // Pipeline control / fetch side drives the inputs and observes the outputs.
  modport master (
    output PC_i, instr_i, instr_valid_i, stall_i, mem_stall_i, flush_i,
`ifdef IF_ID_STATS_EN
    input  stall_cnt_o, bubble_cnt_o,
`endif
    input  PC_o, instr_o, valid_o, RS1addr_o, RS2addr_o, flush_pending_o
  );

  // The pipeline register itself.
  modport slave (
    input  PC_i, instr_i, instr_valid_i, stall_i, mem_stall_i, flush_i,
`ifdef IF_ID_STATS_EN
    output stall_cnt_o, bubble_cnt_o,
`endif
    output PC_o, instr_o, valid_o, RS1addr_o, RS2addr_o, flush_pending_o
  );
endinterface

// File: rtl/if_id_pipe_reg.sv
// rtl/if_id_pipe_reg.sv - IF/ID pipeline register with hold, bubble insertion and deferred flush
// Optional: IF_ID_STATS_EN adds saturating stall and bubble counters.
module if_id_pipe_reg #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk_i,
  input  logic            rst_i,
  if_id_pipe_reg_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            flush_pend_q, flush_pend_d;
  logic            load_bubble;

  // State and slot contents; reset empties the slot and drops any deferred flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= EMPTY;
      pc_q         <= '0;
      instr_q      <= NOP_INSTR;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next-state: freeze > load-use hold > flush (live or deferred) > fetch hit > fetch miss.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    flush_pend_d = flush_pend_q;
    load_bubble  = 1'b0;
    if (bus.mem_stall_i) begin
      // A flush seen while frozen must survive until the pipe moves again.
      if (bus.flush_i) flush_pend_d = 1'b1;
    end else if (bus.stall_i) begin
      // Branch operands are stale during a load-use stall; decode will reassert flush.
    end else if (bus.flush_i || flush_pend_q) begin
      state_d      = EMPTY;
      pc_d         = bus.PC_i;
      instr_d      = NOP_INSTR;
      flush_pend_d = 1'b0;
      load_bubble  = 1'b1;
    end else if (bus.instr_valid_i) begin
      state_d = FULL;
      pc_d    = bus.PC_i;
      instr_d = bus.instr_i;
    end else begin
      state_d     = EMPTY;
      pc_d        = bus.PC_i;
      instr_d     = NOP_INSTR;
      load_bubble = 1'b1;
    end
  end

  // Outputs come only from registers; RS fields are forced to x0 when the slot is empty.
  always_comb begin
    bus.PC_o            = pc_q;
    bus.instr_o         = instr_q;
    bus.valid_o         = (state_q == FULL);
    bus.flush_pending_o = flush_pend_q;
    bus.RS1addr_o       = (state_q == FULL) ? instr_q[19:15] : 5'd0;
    bus.RS2addr_o       = (state_q == FULL) ? instr_q[24:20] : 5'd0;
  end

`ifdef IF_ID_STATS_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  // Saturating counts of stalled cycles and bubble-loading edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if ((bus.stall_i || bus.mem_stall_i) && (stall_cnt_q != 32'hFFFFFFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (load_bubble && (bubble_cnt_q != 32'hFFFFFFFF))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  // Expose the counters.
  always_comb begin
    bus.stall_cnt_o  = stall_cnt_q;
    bus.bubble_cnt_o = bubble_cnt_q;
  end
`else
  logic unused_bubble;
  assign unused_bubble = load_bubble;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb/tb_if_id_pipe_reg.sv - scoreboard testbench for if_id_pipe_reg
module tb_if_id_pipe_reg;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] IA  = 32'h00A28293;  // rs1=5, rs2=10
  localparam logic [31:0] IB  = 32'h00C30313;  // rs1=6, rs2=12

  logic clk;
  logic rst;
  logic chk_now;

  if_id_pipe_reg_if #(.XLEN(32)) bus ();

  if_id_pipe_reg #(.XLEN(32), .NOP_INSTR(32'h00000013)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        pend;
    logic        is_rst;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: after every active edge (or on an async-reset probe) pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge chk_now);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, ".PC_o"},            bus.PC_o,                    e.pc);
        chk({e.name, ".instr_o"},         bus.instr_o,                 e.instr);
        chk({e.name, ".valid_o"},         {31'd0, bus.valid_o},        {31'd0, e.valid});
        chk({e.name, ".RS1addr_o"},       {27'd0, bus.RS1addr_o},      {27'd0, e.rs1});
        chk({e.name, ".RS2addr_o"},       {27'd0, bus.RS2addr_o},      {27'd0, e.rs2});
        chk({e.name, ".flush_pending_o"}, {31'd0, bus.flush_pending_o}, {31'd0, e.pend});
`ifdef IF_ID_STATS_EN
        if (e.is_rst) begin
          chk({e.name, ".stall_cnt_o"},  bus.stall_cnt_o,  32'd0);
          chk({e.name, ".bubble_cnt_o"}, bus.bubble_cnt_o, 32'd0);
        end
`endif
      end
    end
  end

  task automatic push(input logic [31:0] epc, input logic [31:0] ei, input logic ev,
                      input logic [4:0] r1, input logic [4:0] r2, input logic ep,
                      input logic isr, input string nm);
    exp_t e;
    e.pc = epc; e.instr = ei; e.valid = ev; e.rs1 = r1; e.rs2 = r2;
    e.pend = ep; e.is_rst = isr; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge and queue the post-edge expectation.
  task automatic step(input logic [31:0] pc, input logic [31:0] ins, input logic iv,
                      input logic st, input logic ms, input logic fl,
                      input logic [31:0] epc, input logic [31:0] ei, input logic ev,
                      input logic [4:0] r1, input logic [4:0] r2, input logic ep,
                      input string nm);
    @(negedge clk);
    bus.PC_i          = pc;
    bus.instr_i       = ins;
    bus.instr_valid_i = iv;
    bus.stall_i       = st;
    bus.mem_stall_i   = ms;
    bus.flush_i       = fl;
    push(epc, ei, ev, r1, r2, ep, 1'b0, nm);
  endtask

  task automatic probe_reset(input string nm);
    push(32'h0, NOP, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, nm);
    chk_now = 1'b1;
    #1 chk_now = 1'b0;
  endtask

  initial begin
    chk_now           = 1'b0;
    rst               = 1'b1;
    bus.PC_i          = '0;
    bus.instr_i       = '0;
    bus.instr_valid_i = 1'b0;
    bus.stall_i       = 1'b0;
    bus.mem_stall_i   = 1'b0;
    bus.flush_i       = 1'b0;
    #3;
    probe_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    //   PC_i   instr_i iv st ms fl | PC_o   instr_o v  rs1 rs2 pend
    step(32'h04, IA,   1, 0, 0, 0,  32'h04, IA,  1, 5, 10, 0, "load_first");
    step(32'h08, IB,   1, 1, 0, 0,  32'h04, IA,  1, 5, 10, 0, "stall_c1");
    step(32'h0C, 32'h12345678, 1, 1, 0, 0, 32'h04, IA, 1, 5, 10, 0, "stall_c2");
    step(32'h08, IB,   1, 0, 0, 0,  32'h08, IB,  1, 6, 12, 0, "stall_release");
    step(32'h10, IA,   1, 0, 0, 1,  32'h10, NOP, 0, 0, 0,  0, "flush");
    step(32'h14, IA,   1, 0, 0, 0,  32'h14, IA,  1, 5, 10, 0, "refill");
    step(32'h18, IB,   1, 1, 0, 1,  32'h14, IA,  1, 5, 10, 0, "stall_and_flush");
    step(32'h18, IB,   1, 0, 0, 0,  32'h18, IB,  1, 6, 12, 0, "after_stall_flush");
    step(32'h1C, IA,   1, 0, 1, 1,  32'h18, IB,  1, 6, 12, 1, "freeze_c1_flush");
    step(32'h1C, IA,   1, 0, 1, 0,  32'h18, IB,  1, 6, 12, 1, "freeze_c2");
    step(32'h1C, IA,   1, 0, 1, 0,  32'h18, IB,  1, 6, 12, 1, "freeze_c3");
    step(32'h1C, IA,   1, 0, 0, 0,  32'h1C, NOP, 0, 0, 0,  0, "deferred_flush");
    step(32'h20, IB,   1, 0, 0, 0,  32'h20, IB,  1, 6, 12, 0, "load_after_defer");
    step(32'h24, IA,   0, 0, 0, 0,  32'h24, NOP, 0, 0, 0,  0, "fetch_miss");
    step(32'h24, IA,   1, 0, 0, 0,  32'h24, IA,  1, 5, 10, 0, "miss_refill");
    step(32'h28, IB,   1, 0, 1, 0,  32'h24, IA,  1, 5, 10, 0, "freeze_no_flush");
    step(32'h28, IB,   1, 0, 0, 1,  32'h28, NOP, 0, 0, 0,  0, "flush_at_release");
    step(32'h2C, IA,   1, 0, 0, 0,  32'h2C, IA,  1, 5, 10, 0, "no_double_bubble");
    step(32'h30, IB,   1, 0, 1, 1,  32'h2C, IA,  1, 5, 10, 1, "freeze_flush2");
    step(32'h30, IB,   1, 1, 0, 0,  32'h2C, IA,  1, 5, 10, 1, "stall_keeps_pend");
    step(32'h30, IB,   1, 0, 0, 0,  32'h30, NOP, 0, 0, 0,  0, "pend_after_stall");
    step(32'h34, IB,   1, 0, 0, 0,  32'h34, IB,  1, 6, 12, 0, "load_after_pend");
    step(32'h38, IA,   1, 0, 1, 1,  32'h34, IB,  1, 6, 12, 1, "freeze_before_rst");

    // Asynchronous reset in the middle of the freeze, checked before the next edge.
    @(negedge clk);
    #1 rst = 1'b1;
    probe_reset("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
IF/ID pipeline register sitting between the fetch stage (PC + instruction cache) and decode.
Consumes the load-use stall from hazard detection, the branch flush from decode, and the data-cache freeze.
Produces the registered PC/instruction, a valid flag, and the decoded RS1/RS2 addresses that feed back to hazard detection.
Implements hold, bubble insertion, and a deferred-flush latch so no flush is lost during a cache freeze.

Parameters:
XLEN, 32, width of PC and instruction
NOP_INSTR, 32'h00000013, encoding driven on instr_o when slot is empty (addi x0,x0,0)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
PC_i  in  XLEN  PC of instruction being fetched
instr_i  in  XLEN  instruction word from I-cache
instr_valid_i  in  1  I-cache returned instr_i this cycle (0 = fetch miss pending)
stall_i  in  1  load-use stall: hold contents
mem_stall_i  in  1  D-cache miss: freeze whole pipe
flush_i  in  1  taken branch/jump resolved in ID: kill IF/ID
PC_o  out  XLEN  registered PC
instr_o  out  XLEN  registered instruction (NOP_INSTR when empty)
valid_o  out  1  slot holds a live instruction
RS1addr_o  out  5  instr_o[19:15], 0 when empty
RS2addr_o  out  5  instr_o[24:20], 0 when empty
flush_pending_o  out  1  flush latched during freeze, not yet applied

Behaviour:
- Reset (async, immediate): PC_o=0, instr_o=NOP_INSTR, valid_o=0, RS1/RS2addr_o=0, flush_pending_o=0; state EMPTY.
- Two states: EMPTY (valid_o=0), FULL (valid_o=1). All outputs registered; RS addresses derived from registered instr, so zero combinational path from inputs.
- Priority per rising edge, highest first:
  1. mem_stall_i=1: all contents hold. If flush_i=1, set flush_pending. State unchanged.
  2. stall_i=1: contents hold; flush_i ignored this cycle (branch operands not yet valid; decode reasserts). Existing flush_pending kept.
  3. flush_i=1 or flush_pending=1: load bubble (instr_o=NOP_INSTR, valid_o=0, PC_o=PC_i), clear flush_pending, go EMPTY.
  4. instr_valid_i=1: load PC_i/instr_i, valid_o=1, go FULL.
  5. instr_valid_i=0: load bubble, go EMPTY (I-cache miss creates bubble, PC held upstream).
- Latency: one cycle from PC_i/instr_i to PC_o/instr_o.
- flush_pending_o mirrors the internal latch; it is applied on the first cycle with mem_stall_i=0 and stall_i=0, even if flush_i is then 0.
- Flush arriving in the same cycle as mem_stall_i deassertion: case 3 applies normally; no double bubble.
- Reset mid-freeze: latch cleared, EMPTY immediately.

Optional Feature:
IF_ID_STATS_EN: when defined, adds outputs stall_cnt_o[31:0] (cycles with stall_i or mem_stall_i high) and bubble_cnt_o[31:0] (edges loading a bubble, from flush or fetch miss). Both saturate at 32'hFFFFFFFF and reset to 0. When undefined, those ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset then instr_valid_i=1, PC_i=0x04, instr_i=0x00A28293 -> next edge PC_o=0x04, instr_o=0x00A28293, valid_o=1, RS1addr_o=5, RS2addr_o=10.
- FULL with instr 0x00A28293, stall_i=1 for 2 cycles while PC_i=0x08 and instr_i change -> outputs unchanged both cycles; on release, loads 0x08.
- flush_i=1 with PC_i=0x10 -> instr_o=0x00000013, valid_o=0, RS1/RS2addr_o=0; stall_i=1 and flush_i=1 together -> hold, no bubble.
- mem_stall_i=1 for 3 cycles with flush_i pulsed in cycle 1 -> contents hold, flush_pending_o=1 from cycle 2; first edge after release -> bubble loaded, flush_pending_o=0.
- instr_valid_i=0 for one cycle -> valid_o=0, instr_o=NOP_INSTR; next cycle instr_valid_i=1 -> FULL.
- Assert rst_i asynchronously mid-freeze with flush_pending_o=1 -> all outputs at reset values before the next clock edge. With IF_ID_STATS_EN, stall_cnt_o and bubble_cnt_o also read 0.
